// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the ALU: small FIFO of results with branch resolution at enqueue
// and saturating overflow statistics.
module alu_writeback_stage #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_result,
    input  logic         in_zero,
    input  logic         in_equal,
    input  logic         in_overflow,
    input  logic [4:0]   in_rd,
    input  logic         in_wr_en,
    input  logic [2:0]   in_branch_type,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [4:0]   out_rd,
    output logic         out_wr_en,
    output logic         out_zero,
    output logic         out_branch_taken,
    input  logic         clear_ovf,
    output logic [15:0]  ovf_count,
    output logic         ovf_sticky
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    typedef struct packed {
        logic [N-1:0] result;
        logic         zero;
        logic [4:0]   rd;
        logic         wr_en;
        logic         taken;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          enq;
    logic          deq;
    logic          taken_c;
    entry_t        head;

    assign in_ready  = !rst && (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;

    // Branch decision resolved from the flags of the incoming beat
    always_comb begin
        taken_c = 1'b0;
        case (in_branch_type)
            BR_BEQ:            taken_c = in_equal;
            BR_BNE:            taken_c = !in_equal;
            BR_BLT,  BR_BLTU:  taken_c = in_result[0];
            BR_BGE,  BR_BGEU:  taken_c = !in_result[0];
            default:           taken_c = 1'b0;
        endcase
    end

    // Entry storage carries no reset; outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{result: in_result,
                             zero:   in_zero,
                             rd:     in_rd,
                             wr_en:  in_wr_en && (in_rd != 5'd0),
                             taken:  taken_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A clear coinciding with a counted beat leaves that beat counted
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count  <= 16'd0;
            ovf_sticky <= 1'b0;
        end else if (clear_ovf) begin
            ovf_count  <= (enq && in_overflow) ? 16'd1 : 16'd0;
            ovf_sticky <= enq && in_overflow;
        end else if (enq && in_overflow) begin
            if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
            ovf_sticky <= 1'b1;
        end
    end

    always_comb begin
        head = mem[rd_ptr];
        if (!out_valid) head = '0;
    end

    assign out_result       = head.result;
    assign out_rd           = head.rd;
    assign out_wr_en        = head.wr_en;
    assign out_zero         = head.zero;
    assign out_branch_taken = head.taken;

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Registered stage directly downstream of the ALU. It captures each ALU result together with its flags and the instruction's destination and branch info. Entries are held in a small FIFO with valid/ready handshakes on both sides. On the output side it presents a register-file write, a resolved branch decision and accumulated overflow statistics to the writeback/PC logic.

## Interface
- N, 32, datapath width (matches ALU result width)
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_result  in  N  ALU result
- in_zero  in  1  ALU zero flag
- in_equal  in  1  ALU equal flag (a == b)
- in_overflow  in  1  ALU overflow flag
- in_rd  in  5  destination register index
- in_wr_en  in  1  instruction writes rd
- in_branch_type  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 reserved (treated as none)
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_result  out  N  head result
- out_rd  out  5  head rd
- out_wr_en  out  1  head write enable, forced 0 when rd == 0
- out_zero  out  1  head zero flag
- out_branch_taken  out  1  resolved branch decision for head
- clear_ovf  in  1  clear overflow statistics
- ovf_count  out  16  saturating count of accepted beats with overflow
- ovf_sticky  out  1  set by any accepted overflow beat, cleared only by clear_ovf/rst

## Operation
- Enqueue when in_valid && in_ready. Dequeue when out_valid && out_ready.
- Storage is a circular buffer with DEPTH entries and separate wr_ptr and rd_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH. An occupancy count ranges over 0..DEPTH.
- in_ready = !rst && (count < DEPTH). There is no full-bypass: when full, in_ready is 0 even if a dequeue happens in the same cycle.
- out_valid = (count != 0). While out_valid is 0, all out_* data outputs are driven to 0.
- Branch resolution is computed at enqueue and stored per entry:
  - BEQ: taken = equal.
  - BNE: taken = !equal.
  - BLT/BLTU: taken = result[0]. The ALU executed SLT or SLTU.
  - BGE/BGEU: taken = !result[0].
  - None/reserved: taken = 0.
- Write enable is stored as in_wr_en && (in_rd != 0).
- Overflow statistics:
  - An accepted beat with in_overflow=1 sets ovf_sticky and increments ovf_count.
  - ovf_count saturates at 0xFFFF.
  - If clear_ovf and a counted beat occur in the same cycle, the result is ovf_count=1 and ovf_sticky=1.
  - clear_ovf alone gives ovf_count=0 and ovf_sticky=0.

## Timing
- Reset values: count=0, wr_ptr=rd_ptr=0, out_valid=0, all out_* data=0, ovf_count=0, ovf_sticky=0, in_ready=0 while rst is high and 1 on the first cycle after.
- Latency: a beat accepted at edge k appears on out_* with out_valid=1 after edge k (one cycle). There is no combinational path from in_* to out_*.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Empty: out_valid=0; out_ready is ignored.
- Full: in_ready=0; upstream must hold in_* stable until it is accepted.
- Head data stays stable while out_valid && !out_ready.
- Reset asserted mid-operation discards all entries and clears the statistics at that edge. Beats presented during reset are not accepted.
- Pointer wrap: after DEPTH enqueues, wr_ptr returns to 0. Ordering is strictly FIFO.

## Test plan
- Reset then single beat: result=0x0000_0005, rd=3, wr_en=1, no branch, out_ready=1 → one cycle later out_valid=1, out_result=5, out_wr_en=1; the next cycle out_valid=0.
- Backpressure: hold out_ready=0 and offer 3 beats (DEPTH=2) → in_ready drops to 0 after 2 accepts and the third beat is held. Raise out_ready and expect 3 outputs in order.
- Branches:
  - BEQ with equal=1 → taken=1.
  - BNE with equal=1 → taken=0.
  - BLTU with result=1 → taken=1.
  - BGE with result=1 → taken=0.
  - Type 7 → taken=0.
- rd=0 with wr_en=1 → out_wr_en=0 and out_result still passed through unchanged.
- Overflow:
  - 3 beats with overflow=1 → ovf_count=3, ovf_sticky=1.
  - clear_ovf in the same cycle as an overflow beat → ovf_count=1.
  - Force 0xFFFF, then one more overflow beat → count stays 0xFFFF.
- Reset with 2 entries queued → next cycle out_valid=0, ovf_count=0, in_ready=1. A new beat then emerges with correct data.
